// File: rtl/bottling_line_ctrl_pkg.sv
// Shared definitions for the bottling line station controller:
// state codes, fault codes and default parameters.
package bottling_line_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ADVANCE    = 3'd1,
      ST_FILL       = 3'd2,
      ST_SEAL       = 3'd3,
      ST_RELEASE    = 3'd4,
      ST_BATCH_HALT = 3'd5,
      ST_FAULT      = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE    = 2'd0,
      FC_FILL_TO = 2'd1,
      FC_SEAL_TO = 2'd2,
      FC_CORK    = 2'd3
   } fault_code_t;

   localparam int DEF_BATCH_SIZE   = 65;
   localparam int DEF_FILL_TIMEOUT = 200;
   localparam int DEF_SEAL_TIMEOUT = 50;
   localparam int DEF_TIMER_W      = 8;

endpackage

// File: rtl/bottling_line_ctrl_line_timer.sv
// Saturating step timer: cleared on state entry, counts cycles spent
// in the current state.
module line_timer #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_value
);

   logic [W-1:0] r_value;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_value <= '0;
      end else if (i_clr) begin
         r_value <= '0;
      end else if (i_en && (r_value != {W{1'b1}})) begin
         r_value <= r_value + 1'b1;
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/bottling_line_ctrl.sv
// One bottling station: advance, fill, seal, release, with batch
// counting, stop handling and coded step-timeout faults.
module bottling_line_ctrl
   import bottling_line_ctrl_pkg::*;
#(
   parameter int BATCH_SIZE   = DEF_BATCH_SIZE,
   parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT,
   parameter int SEAL_TIMEOUT = DEF_SEAL_TIMEOUT,
   parameter int TIMER_W      = DEF_TIMER_W
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       STOP,
   input  logic       ACK_FAULT,
   input  logic       BOTTLE_AT_FILL,
   input  logic       LEVEL_OK,
   input  logic       SEAL_DONE,
   input  logic       CORK_EMPTY,
   output logic       CONVEYOR_EN,
   output logic       VALVE_OPEN,
   output logic       SEAL_CMD,
   output logic       BATCH_DONE,
   output logic       FAULT,
   output logic [1:0] FAULT_CODE,
   output logic [6:0] count,
   output logic [2:0] state
);

   localparam logic [6:0]         BS_C      = 7'(BATCH_SIZE);
   localparam logic [TIMER_W-1:0] FILL_TO_C = TIMER_W'(FILL_TIMEOUT);
   localparam logic [TIMER_W-1:0] SEAL_TO_C = TIMER_W'(SEAL_TIMEOUT);

   state_t       r_state;
   fault_code_t  r_code;
   logic [6:0]   r_count;
   logic         r_stop_pending;
   logic         r_conv;
   logic         r_valve;
   logic         r_seal;
   logic         r_batch_done;
   logic         r_fault;
   fault_code_t  r_fcode;

   state_t       w_state_nxt;
   fault_code_t  w_code_nxt;
   logic [6:0]   w_count_nxt;
   logic         w_stop_nxt;
   logic         w_seal_fire;
   logic         w_entry;
   logic         w_timer_clr;
   logic [TIMER_W-1:0] w_timer;

   line_timer #(.W(TIMER_W)) u_timer (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_clr   (w_timer_clr),
      .i_en    (1'b1),
      .o_value (w_timer)
   );

   assign w_entry     = (w_timer == '0);
   assign w_timer_clr = (w_state_nxt != r_state);

   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_count_nxt = r_count;
      w_stop_nxt  = r_stop_pending;
      w_seal_fire = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (START && !STOP) w_state_nxt = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            if (BOTTLE_AT_FILL) w_state_nxt = ST_FILL;
            else if (STOP)      w_state_nxt = ST_IDLE;
         end
         ST_FILL: begin
            if (LEVEL_OK) begin
               w_state_nxt = ST_SEAL;
            end else if (w_timer == FILL_TO_C) begin
               w_state_nxt = ST_FAULT;
               w_code_nxt  = FC_FILL_TO;
            end
         end
         ST_SEAL: begin
            // An empty magazine is only sampled as the seal step opens
            if (w_entry && CORK_EMPTY) begin
               w_state_nxt = ST_FAULT;
               w_code_nxt  = FC_CORK;
            end else begin
               w_seal_fire = w_entry;
               if (SEAL_DONE) begin
                  w_state_nxt = ST_RELEASE;
                  if (r_count != BS_C) w_count_nxt = r_count + 7'd1;
               end else if (w_timer == SEAL_TO_C) begin
                  w_state_nxt = ST_FAULT;
                  w_code_nxt  = FC_SEAL_TO;
               end
            end
         end
         ST_RELEASE: begin
            if (!BOTTLE_AT_FILL) begin
               if (r_count == BS_C)               w_state_nxt = ST_BATCH_HALT;
               else if (r_stop_pending || STOP)   w_state_nxt = ST_IDLE;
               else                               w_state_nxt = ST_ADVANCE;
            end
         end
         ST_BATCH_HALT: begin
            if (START) begin
               w_state_nxt = ST_ADVANCE;
               w_count_nxt = '0;
            end
         end
         ST_FAULT: begin
            if (ACK_FAULT) begin
               w_state_nxt = ST_IDLE;
               w_code_nxt  = FC_NONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_state_nxt == ST_IDLE) begin
         w_stop_nxt = 1'b0;
      end else if (STOP && ((r_state == ST_FILL) ||
                            (r_state == ST_SEAL) ||
                            (r_state == ST_RELEASE))) begin
         w_stop_nxt = 1'b1;
      end
   end

   // Actuator registers are driven from the present state, so they lag it
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state        <= ST_IDLE;
         r_code         <= FC_NONE;
         r_count        <= '0;
         r_stop_pending <= 1'b0;
         r_conv         <= 1'b0;
         r_valve        <= 1'b0;
         r_seal         <= 1'b0;
         r_batch_done   <= 1'b0;
         r_fault        <= 1'b0;
         r_fcode        <= FC_NONE;
      end else begin
         r_state        <= w_state_nxt;
         r_code         <= w_code_nxt;
         r_count        <= w_count_nxt;
         r_stop_pending <= w_stop_nxt;
         r_conv         <= (r_state == ST_ADVANCE) ||
                           (r_state == ST_RELEASE);
         r_valve        <= (r_state == ST_FILL);
         r_seal         <= w_seal_fire;
         r_batch_done   <= (r_state == ST_BATCH_HALT);
         r_fault        <= (r_state == ST_FAULT);
         r_fcode        <= (r_state == ST_FAULT) ? r_code : FC_NONE;
      end
   end

   assign CONVEYOR_EN = r_conv;
   assign VALVE_OPEN  = r_valve;
   assign SEAL_CMD    = r_seal;
   assign BATCH_DONE  = r_batch_done;
   assign FAULT       = r_fault;
   assign FAULT_CODE  = r_fcode;
   assign count       = r_count;
   assign state       = r_state;

endmodule

// File: tb/tb_bottling_line_ctrl.sv
// Bench for bottling_line_ctrl: directed scenarios plus random sensor
// traffic, all compared against a cycle-level reference of the station.
module tb_bottling_line_ctrl;

   localparam int BS = 3;
   localparam int FT = 40;
   localparam int ST = 20;
   localparam int TW = 8;
   localparam int TMAX = 255;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic START = 1'b0, STOP = 1'b0, ACK_FAULT = 1'b0;
   logic BOTTLE_AT_FILL = 1'b0, LEVEL_OK = 1'b0;
   logic SEAL_DONE = 1'b0, CORK_EMPTY = 1'b0;
   logic CONVEYOR_EN, VALVE_OPEN, SEAL_CMD, BATCH_DONE, FAULT;
   logic [1:0] FAULT_CODE;
   logic [6:0] count;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;
   int seals  = 0;

   // reference: phase number, cycles in phase, bottles, fault code
   int ms, age, mcount, mcode;
   bit mstop;
   int e_conv, e_valve, e_seal, e_bd, e_fault, e_code;

   bottling_line_ctrl #(
      .BATCH_SIZE  (BS),
      .FILL_TIMEOUT(FT),
      .SEAL_TIMEOUT(ST),
      .TIMER_W     (TW)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .START         (START),
      .STOP          (STOP),
      .ACK_FAULT     (ACK_FAULT),
      .BOTTLE_AT_FILL(BOTTLE_AT_FILL),
      .LEVEL_OK      (LEVEL_OK),
      .SEAL_DONE     (SEAL_DONE),
      .CORK_EMPTY    (CORK_EMPTY),
      .CONVEYOR_EN   (CONVEYOR_EN),
      .VALVE_OPEN    (VALVE_OPEN),
      .SEAL_CMD      (SEAL_CMD),
      .BATCH_DONE    (BATCH_DONE),
      .FAULT         (FAULT),
      .FAULT_CODE    (FAULT_CODE),
      .count         (count),
      .state         (state)
   );

   always #5 CLK = ~CLK;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ms = 0; age = 0; mcount = 0; mcode = 0; mstop = 0;
      e_conv = 0; e_valve = 0; e_seal = 0;
      e_bd = 0; e_fault = 0; e_code = 0;
   endtask

   task automatic model_step();
      int ns;
      e_conv  = (ms == 1 || ms == 4) ? 1 : 0;
      e_valve = (ms == 2) ? 1 : 0;
      e_seal  = (ms == 3 && age == 0 && !CORK_EMPTY) ? 1 : 0;
      e_bd    = (ms == 5) ? 1 : 0;
      e_fault = (ms == 6) ? 1 : 0;
      e_code  = (ms == 6) ? mcode : 0;
      ns = ms;
      case (ms)
         0: if (START && !STOP) ns = 1;
         1: if (BOTTLE_AT_FILL) ns = 2; else if (STOP) ns = 0;
         2: if (LEVEL_OK) ns = 3;
            else if (age == FT) begin ns = 6; mcode = 1; end
         3: if (age == 0 && CORK_EMPTY) begin ns = 6; mcode = 3; end
            else if (SEAL_DONE) begin
               ns = 4;
               if (mcount < BS) mcount++;
            end else if (age == ST) begin ns = 6; mcode = 2; end
         4: if (!BOTTLE_AT_FILL)
               ns = (mcount == BS) ? 5 : ((mstop || STOP) ? 0 : 1);
         5: if (START) begin ns = 1; mcount = 0; end
         6: if (ACK_FAULT) begin ns = 0; mcode = 0; end
         default: ns = 0;
      endcase
      if (ns == 0) mstop = 0;
      else if (STOP && ms >= 2 && ms <= 4) mstop = 1;
      age = (ns != ms) ? 0 : ((age < TMAX) ? age + 1 : TMAX);
      ms = ns;
   endtask

   task automatic compare_all();
      chk("conveyor", CONVEYOR_EN, e_conv);
      chk("valve", VALVE_OPEN, e_valve);
      chk("seal_cmd", SEAL_CMD, e_seal);
      chk("batch_done", BATCH_DONE, e_bd);
      chk("fault", FAULT, e_fault);
      chk("fault_code", FAULT_CODE, e_code);
      chk("count", count, mcount);
      chk("state", state, ms);
      if (SEAL_CMD === 1'b1) seals++;
   endtask

   task automatic step();
      @(posedge CLK);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // from ADVANCE: one bottle through fill, seal and release
   task automatic cycle_bottle(int fw, int sw, bit stop_mid);
      BOTTLE_AT_FILL = 1; step();
      if (stop_mid) begin STOP = 1; step(); STOP = 0; end
      run(fw);
      LEVEL_OK = 1; step(); LEVEL_OK = 0;
      run(sw);
      SEAL_DONE = 1; step(); SEAL_DONE = 0;
      run(2);
      BOTTLE_AT_FILL = 0; step();
      run(1);
   endtask

   task automatic random_phase(int n, int lvl_div);
      for (int i = 0; i < n; i++) begin
         START      = ($urandom % 5 == 0);
         STOP       = ($urandom % 25 == 0);
         ACK_FAULT  = ($urandom % 10 == 0);
         if ($urandom % 6 == 0) BOTTLE_AT_FILL = ~BOTTLE_AT_FILL;
         LEVEL_OK   = ($urandom % lvl_div == 0);
         SEAL_DONE  = ($urandom % 8 == 0);
         CORK_EMPTY = ($urandom % 15 == 0);
         step();
      end
      START = 0; STOP = 0; ACK_FAULT = 0;
      LEVEL_OK = 0; SEAL_DONE = 0; CORK_EMPTY = 0;
   endtask

   initial begin
      model_reset();
      #1 RST = 0;
      #2;
      compare_all();
      #9 RST = 1;

      // normal bottle
      seals = 0;
      START = 1; step(); START = 0;
      run(4);
      cycle_bottle(10, 5, 0);
      chk("t1_state", state, 1);
      chk("t1_count", count, 1);
      chk("t1_seals", seals, 1);

      // fill timeout, count kept
      BOTTLE_AT_FILL = 1; step();
      run(FT + 5);
      chk("t3_state", state, 6);
      chk("t3_fault", FAULT, 1);
      chk("t3_code", FAULT_CODE, 1);
      ACK_FAULT = 1; step(); ACK_FAULT = 0;
      BOTTLE_AT_FILL = 0; run(1);
      chk("t3_idle", state, 0);
      chk("t3_count", count, 1);
      chk("t3_fault_clr", FAULT, 0);

      // complete the batch
      START = 1; step(); START = 0;
      cycle_bottle(7, 3, 0);
      cycle_bottle(12, 9, 0);
      chk("t2_state", state, 5);
      chk("t2_done", BATCH_DONE, 1);
      chk("t2_count", count, BS);
      run(3);
      chk("t2_hold", count, BS);
      START = 1; step(); START = 0;
      run(1);
      chk("t2_restart", state, 1);
      chk("t2_count0", count, 0);

      // empty cork magazine
      seals = 0;
      BOTTLE_AT_FILL = 1; step();
      run(3);
      CORK_EMPTY = 1; LEVEL_OK = 1; step(); LEVEL_OK = 0;
      run(3);
      chk("t4_code", FAULT_CODE, 3);
      chk("t4_fault", FAULT, 1);
      chk("t4_noseal", seals, 0);
      ACK_FAULT = 1; CORK_EMPTY = 0; BOTTLE_AT_FILL = 0; step();
      ACK_FAULT = 0; run(1);
      chk("t4_idle", state, 0);

      // stop during fill
      START = 1; step(); START = 0;
      cycle_bottle(5, 4, 1);
      chk("t5_state", state, 0);
      chk("t5_conv", CONVEYOR_EN, 0);
      chk("t5_count", count, 1);

      // async reset while filling
      START = 1; step(); START = 0;
      BOTTLE_AT_FILL = 1; step();
      run(3);
      chk("t6_valve_on", VALVE_OPEN, 1);
      #1 RST = 0;
      #1;
      chk("t6_valve_off", VALVE_OPEN, 0);
      chk("t6_state", state, 0);
      chk("t6_count", count, 0);
      @(posedge CLK);
      #2 RST = 1;
      BOTTLE_AT_FILL = 0;
      model_reset();

      random_phase(1500, 8);
      random_phase(1500, 70);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
